// File: rtl/gpr_file_mp.sv
// gpr_file_mp -- parametrised general-purpose register file (AX..DI).
//
// Eight DATA_W-bit registers with two write ports and NUM_RD registered read
// ports. Every access has a size (byte / word / dword). Writes change only
// the byte lanes they address. Reads and the address taps are taken from the
// post-write register value, so data written at an edge is visible in the
// values registered at that same edge.
//
// Ports:
//   clk                 clock
//   reset               asynchronous, active-high
//   rd_sel/rd_size[i]   read select / size (00 byte, 01 word, 10 dword, 11 = word)
//   rd_val[i]           registered read data, zero-extended
//   wr_en/wr_sel/wr_size/wr_val[p]  write port p (0..1); port 1 wins on shared lanes
//   si, di, bp, bx      registered low 16 bits of registers 6, 7, 5, 3
module gpr_file_mp #(
  parameter int          DATA_W   = 16,
  parameter int          NUM_RD   = 2,
  parameter logic [15:0] SP_RESET = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        rd_sel  [NUM_RD],
  input  logic [1:0]        rd_size [NUM_RD],
  output logic [DATA_W-1:0] rd_val  [NUM_RD],
  input  logic              wr_en   [2],
  input  logic [2:0]        wr_sel  [2],
  input  logic [1:0]        wr_size [2],
  input  logic [DATA_W-1:0] wr_val  [2],
  output logic [15:0]       si,
  output logic [15:0]       di,
  output logic [15:0]       bp,
  output logic [15:0]       bx
);

  localparam int         NLANE    = DATA_W / 8;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_DWORD = 2'b10;

  logic [DATA_W-1:0] regs     [8];
  logic [DATA_W-1:0] regs_nxt [8];
  logic [DATA_W-1:0] rd_nxt   [NUM_RD];

  // Per-port decoded write: target register, lane mask, lane-aligned data.
  logic [2:0]        wr_idx   [2];
  logic [NLANE-1:0]  wr_lanes [2];
  logic [DATA_W-1:0] wr_data  [2];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      // NOTE: every signal written here gets a default first, so no path
      // through the size decode can leave one unassigned and infer a latch.
      wr_idx[p]   = wr_sel[p];
      wr_lanes[p] = '0;
      wr_data[p]  = '0;
      if (wr_size[p] == SZ_BYTE) begin
        // Byte: sel[2] picks the high byte (AH..BH) of register sel[1:0].
        // The byte is placed on both low lanes; the mask picks the one used.
        wr_idx[p]        = {1'b0, wr_sel[p][1:0]};
        wr_data[p][7:0]  = wr_val[p][7:0];
        wr_data[p][15:8] = wr_val[p][7:0];
        if (wr_sel[p][2]) wr_lanes[p][1] = 1'b1;
        else              wr_lanes[p][0] = 1'b1;
      end else if (wr_size[p] == SZ_DWORD && DATA_W == 32) begin
        wr_lanes[p] = '1;
        wr_data[p]  = wr_val[p];
      end else begin
        // Word, reserved size 11, and dword on a 16-bit file.
        wr_lanes[p][1:0] = 2'b11;
        wr_data[p][15:0] = wr_val[p][15:0];
      end
      if (!wr_en[p]) wr_lanes[p] = '0;
    end
  end

  // Lane merge: port 0 applied first, then port 1, so port 1 owns any lane
  // both ports touch while disjoint lanes from both ports survive.
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      regs_nxt[r] = regs[r];
      for (int p = 0; p < 2; p++) begin
        if (wr_idx[p] == 3'(r)) begin
          for (int l = 0; l < NLANE; l++) begin
            if (wr_lanes[p][l]) regs_nxt[r][l*8 +: 8] = wr_data[p][l*8 +: 8];
          end
        end
      end
    end
  end

  // Read muxes see the merged post-write value (write-first, lane-exact).
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_nxt[i] = '0;
      if (rd_size[i] == SZ_BYTE) begin
        if (rd_sel[i][2]) rd_nxt[i][7:0] = regs_nxt[{1'b0, rd_sel[i][1:0]}][15:8];
        else              rd_nxt[i][7:0] = regs_nxt[{1'b0, rd_sel[i][1:0]}][7:0];
      end else if (rd_size[i] == SZ_DWORD && DATA_W == 32) begin
        rd_nxt[i] = regs_nxt[rd_sel[i]];
      end else begin
        rd_nxt[i][15:0] = regs_nxt[rd_sel[i]][15:0];
      end
    end
  end

  // NOTE: the register array is reset like any other flop because software
  // relies on AX..DI being 0 (and SP preset) out of reset; it is small enough
  // to live in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 8; r++) begin
        regs[r] <= (r == 4) ? DATA_W'(SP_RESET) : '0;
      end
      for (int i = 0; i < NUM_RD; i++) begin
        rd_val[i] <= '0;
      end
      si <= '0;
      di <= '0;
      bp <= '0;
      bx <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every flop updates from
      // the pre-edge values regardless of statement order.
      for (int r = 0; r < 8; r++) begin
        regs[r] <= regs_nxt[r];
      end
      for (int i = 0; i < NUM_RD; i++) begin
        rd_val[i] <= rd_nxt[i];
      end
      si <= regs_nxt[6][15:0];
      di <= regs_nxt[7][15:0];
      bp <= regs_nxt[5][15:0];
      bx <= regs_nxt[3][15:0];
    end
  end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Testbench for gpr_file_mp. Two instances share the stimulus: a 32-bit file
// with four read ports and a 16-bit file with two read ports. A reference
// model applies each write port in turn to plain arrays and predicts reads.
module tb_gpr_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  rd_sel   [4];
  logic [1:0]  rd_size  [4];
  logic [31:0] rd_val32 [4];
  logic [2:0]  rd_sel16 [2];
  logic [1:0]  rd_size16[2];
  logic [15:0] rd_val16 [2];
  logic        wr_en    [2];
  logic [2:0]  wr_sel   [2];
  logic [1:0]  wr_size  [2];
  logic [31:0] wr_val   [2];
  logic [15:0] wr_val16 [2];
  logic [15:0] si32, di32, bp32, bx32;
  logic [15:0] si16, di16, bp16, bx16;

  assign rd_sel16[0]  = rd_sel[0];
  assign rd_sel16[1]  = rd_sel[1];
  assign rd_size16[0] = rd_size[0];
  assign rd_size16[1] = rd_size[1];
  assign wr_val16[0]  = wr_val[0][15:0];
  assign wr_val16[1]  = wr_val[1][15:0];

  gpr_file_mp #(.DATA_W(32), .NUM_RD(4), .SP_RESET(16'hFFFE)) dut32 (
    .clk(clk), .reset(reset),
    .rd_sel(rd_sel), .rd_size(rd_size), .rd_val(rd_val32),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_size(wr_size), .wr_val(wr_val),
    .si(si32), .di(di32), .bp(bp32), .bx(bx32)
  );

  gpr_file_mp #(.DATA_W(16), .NUM_RD(2), .SP_RESET(16'h1234)) dut16 (
    .clk(clk), .reset(reset),
    .rd_sel(rd_sel16), .rd_size(rd_size16), .rd_val(rd_val16),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_size(wr_size), .wr_val(wr_val16),
    .si(si16), .di(di16), .bp(bp16), .bx(bx16)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference register contents for the 32-bit and 16-bit files.
  logic [31:0] m32 [8];
  logic [31:0] m16 [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) begin
      m32[r] = '0;
      m16[r] = '0;
    end
    m32[4] = 32'h0000_FFFE;
    m16[4] = 32'h0000_1234;
  endtask

  // One write as the instruction set defines it: byte to AL..BL / AH..BH,
  // word to the low half, dword to the whole register (word on a 16-bit file).
  task automatic model_write(input bit wide, input logic [2:0] sel,
                             input logic [1:0] size, input logic [31:0] val);
    int          idx;
    logic [31:0] r;
    idx = (size == 2'b00) ? int'(sel[1:0]) : int'(sel);
    r   = wide ? m32[idx] : m16[idx];
    if (size == 2'b00) begin
      if (sel[2]) r[15:8] = val[7:0];
      else        r[7:0]  = val[7:0];
    end else if (size == 2'b10 && wide) begin
      r = val;
    end else begin
      r[15:0] = val[15:0];
    end
    if (wide) m32[idx] = r;
    else      m16[idx] = r;
  endtask

  function automatic logic [31:0] model_read(input bit wide, input logic [2:0] sel,
                                             input logic [1:0] size);
    logic [31:0] r;
    if (size == 2'b00) begin
      r = wide ? m32[sel[1:0]] : m16[sel[1:0]];
      return sel[2] ? {24'h0, r[15:8]} : {24'h0, r[7:0]};
    end
    r = wide ? m32[sel] : m16[sel];
    if (size == 2'b10 && wide) return r;
    return {16'h0, r[15:0]};
  endfunction

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      wr_en[p]   = 1'b0;
      wr_sel[p]  = '0;
      wr_size[p] = 2'b01;
      wr_val[p]  = '0;
    end
  endtask

  task automatic set_wr(input int p, input logic [2:0] sel, input logic [1:0] size,
                        input logic [31:0] val);
    wr_en[p]   = 1'b1;
    wr_sel[p]  = sel;
    wr_size[p] = size;
    wr_val[p]  = val;
  endtask

  task automatic set_rd(input int i, input logic [2:0] sel, input logic [1:0] size);
    rd_sel[i]  = sel;
    rd_size[i] = size;
  endtask

  // Apply current inputs for one edge, then compare every output to the model.
  task automatic step();
    for (int p = 0; p < 2; p++) begin
      if (wr_en[p]) begin
        model_write(1'b1, wr_sel[p], wr_size[p], wr_val[p]);
        model_write(1'b0, wr_sel[p], wr_size[p], {16'h0, wr_val[p][15:0]});
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("rd32[%0d]", i), rd_val32[i], model_read(1'b1, rd_sel[i], rd_size[i]));
    for (int i = 0; i < 2; i++)
      check($sformatf("rd16[%0d]", i), {16'h0, rd_val16[i]}, model_read(1'b0, rd_sel[i], rd_size[i]));
    check("si32", {16'h0, si32}, {16'h0, m32[6][15:0]});
    check("di32", {16'h0, di32}, {16'h0, m32[7][15:0]});
    check("bp32", {16'h0, bp32}, {16'h0, m32[5][15:0]});
    check("bx32", {16'h0, bx32}, {16'h0, m32[3][15:0]});
    check("si16", {16'h0, si16}, {16'h0, m16[6][15:0]});
    check("di16", {16'h0, di16}, {16'h0, m16[7][15:0]});
    check("bp16", {16'h0, bp16}, {16'h0, m16[5][15:0]});
    check("bx16", {16'h0, bx16}, {16'h0, m16[3][15:0]});
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int i = 0; i < 4; i++) check($sformatf("%s rd32[%0d]", tag, i), rd_val32[i], 32'h0);
    for (int i = 0; i < 2; i++) check($sformatf("%s rd16[%0d]", tag, i), {16'h0, rd_val16[i]}, 32'h0);
    check({tag, " taps32"}, {si32, di32}, 32'h0);
    check({tag, " taps32b"}, {bp32, bx32}, 32'h0);
    check({tag, " taps16"}, {si16, di16}, 32'h0);
    check({tag, " taps16b"}, {bp16, bx16}, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) set_rd(i, 3'd0, 2'b01);
    model_reset();

    // 1. Reset: outputs clear immediately; SP comes up at SP_RESET.
    #2 reset = 1'b1;
    #1 check_outputs_zero("reset_async");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    set_rd(0, 3'd4, 2'b01);
    set_rd(1, 3'd0, 2'b01);
    step();
    check("t1_sp32", rd_val32[0], 32'h0000_FFFE);
    check("t1_ax32", rd_val32[1], 32'h0);
    check("t1_sp16", {16'h0, rd_val16[0]}, 32'h0000_1234);

    // 2. Lane merge and lane-exact forwarding.
    set_wr(0, 3'd0, 2'b01, 32'h0000_1234);
    step();
    set_wr(0, 3'd4, 2'b00, 32'h0000_00AB);
    set_rd(0, 3'd0, 2'b00);
    set_rd(1, 3'd0, 2'b01);
    step();
    check("t2_al_fwd", rd_val32[0], 32'h0000_0034);
    check("t2_ax_fwd", rd_val32[1], 32'h0000_AB34);
    idle();
    set_rd(0, 3'd0, 2'b01);
    step();
    check("t2_ax", rd_val32[0], 32'h0000_AB34);

    // 3. Dual write: overlapping lane goes to port 1; XCHG writes both.
    set_wr(0, 3'd0, 2'b01, 32'h0000_1111);
    set_wr(1, 3'd0, 2'b00, 32'h0000_0022);
    step();
    check("t3_collide", rd_val32[0], 32'h0000_1122);
    set_wr(0, 3'd1, 2'b01, 32'h0000_5555);
    set_wr(1, 3'd2, 2'b01, 32'h0000_6666);
    set_rd(0, 3'd1, 2'b01);
    set_rd(1, 3'd2, 2'b01);
    step();
    check("t3_cx", rd_val32[0], 32'h0000_5555);
    check("t3_dx", rd_val32[1], 32'h0000_6666);

    // 4. Wide mode: word keeps the upper half; reserved size acts as word.
    idle();
    set_wr(0, 3'd0, 2'b10, 32'hDEAD_BEEF);
    set_rd(0, 3'd0, 2'b10);
    step();
    set_wr(0, 3'd0, 2'b01, 32'h0000_0000);
    step();
    check("t4_word_keep", rd_val32[0], 32'hDEAD_0000);
    set_wr(0, 3'd0, 2'b10, 32'hCAFE_F00D);
    set_rd(1, 3'd4, 2'b00);
    step();
    check("t4_ah", rd_val32[1], 32'h0000_00F0);
    check("t4_dw16", {16'h0, rd_val16[0]}, 32'h0000_F00D);
    set_wr(0, 3'd0, 2'b11, 32'h1234_5678);
    step();
    check("t4_rsvd", rd_val32[0], 32'hCAFE_5678);

    // 5. Address taps follow writes at the committing edge.
    idle();
    set_wr(0, 3'd3, 2'b01, 32'h0000_1200);
    step();
    set_wr(0, 3'd3, 2'b00, 32'h0000_007F);
    step();
    check("t5_bx", {16'h0, bx32}, 32'h0000_127F);
    set_wr(0, 3'd6, 2'b01, 32'h0000_4000);
    step();
    check("t5_si", {16'h0, si32}, 32'h0000_4000);

    // 6. Random traffic on both write ports and all read ports.
    for (int c = 0; c < 10000; c++) begin
      for (int p = 0; p < 2; p++) begin
        wr_en[p]   = 1'($urandom_range(0, 1));
        wr_sel[p]  = 3'($urandom);
        wr_size[p] = 2'($urandom);
        wr_val[p]  = $urandom;
      end
      for (int i = 0; i < 4; i++) set_rd(i, 3'($urandom), 2'($urandom));
      step();
    end

    // Mid-cycle reset: clears at once; writes held during reset are dropped.
    @(posedge clk);
    #3 reset = 1'b1;
    set_wr(0, 3'd0, 2'b10, 32'hFFFF_FFFF);
    set_wr(1, 3'd4, 2'b01, 32'h0000_0000);
    #1 check_outputs_zero("reset_mid");
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle();
    set_rd(0, 3'd0, 2'b10);
    set_rd(1, 3'd4, 2'b01);
    step();
    check("rst_ax_dropped", rd_val32[0], 32'h0);
    check("rst_sp", rd_val32[1], 32'h0000_FFFE);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
